// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 64-point FFT output stages.
package fft_pkg;

  localparam int FFT_N        = 64;
  localparam int FFT_LOGN     = 6;
  localparam int FFT_HALF     = 32;
  localparam int SAMPLE_WIDTH = 18;

  // Drain sequencer state, also exported for debug observation.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  // Subcarrier index of a natural-order bin: bin for 0..31, bin-64 for 32..63.
  function automatic logic [FFT_LOGN-1:0] bin_to_k(input logic [FFT_LOGN-1:0] bin);
    logic [FFT_LOGN:0] wide;
    wide = {1'b0, bin};
    if (bin < FFT_LOGN'(FFT_HALF)) begin
      return bin;
    end
    wide = wide - (FFT_LOGN+1)'(FFT_N);
    return wide[FFT_LOGN-1:0];
  endfunction

endpackage

// File: rtl/fft_shift64_if.sv
// Sample stream bundle between the reorder stage, fft_shift64 and the demapper.
//
// Handshake: di_en and do_en are pure valid strobes with no ready/back-pressure.
// A sample transfers on every rising clk edge where its valid is 1; the
// receiver must accept every valid sample. Data, do_k and do_sof are only
// meaningful with valid high and are driven to 0 otherwise on the output side.
interface fft_shift64_if import fft_pkg::*; #(parameter int WIDTH = SAMPLE_WIDTH);

  logic signed [WIDTH-1:0]    di_re;
  logic signed [WIDTH-1:0]    di_im;
  logic                       di_en;

  logic signed [WIDTH-1:0]    do_re;
  logic signed [WIDTH-1:0]    do_im;
  logic                       do_en;
  logic signed [FFT_LOGN-1:0] do_k;
  logic                       do_sof;

  drain_state_t               dbg_state;

  modport master (
    output di_re, di_im, di_en,
    input  do_re, do_im, do_en, do_k, do_sof, dbg_state
  );

  modport slave (
    input  di_re, di_im, di_en,
    output do_re, do_im, do_en, do_k, do_sof, dbg_state
  );

endinterface

// File: rtl/shift_ram.sv
// Ping-pong buffer: 2 banks x 32 words, one write port, one registered read port.
// The bank select is the address MSB. Contents are never cleared.
module shift_ram import fft_pkg::*; #(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [FFT_LOGN-1:0]   waddr,
  input  logic [2*WIDTH-1:0]    wdata,
  input  logic                  re,
  input  logic [FFT_LOGN-1:0]   raddr,
  output logic [2*WIDTH-1:0]    rdata
);

  logic [2*WIDTH-1:0] mem [FFT_N];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value when not reading.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_shift64.sv
// fftshift reorder for 64-point frames: bins 32..63 pass through one register,
// bins 0..31 are buffered in a ping-pong RAM and drained right after bin 63.
module fft_shift64 import fft_pkg::*; #(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  fft_shift64_if.slave  bus
);

  logic [FFT_LOGN-1:0]   in_cnt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [FFT_LOGN-2:0]   rd_cnt;
  drain_state_t          state_q;
  drain_state_t          state_d;

  logic                  pass_en;
  logic signed [WIDTH-1:0] pass_re;
  logic signed [WIDTH-1:0] pass_im;
  logic [FFT_LOGN-1:0]   pass_k;
  logic                  pass_sof;

  logic                  rd_valid;
  logic [FFT_LOGN-1:0]   rd_k;
  logic [2*WIDTH-1:0]    rdata;

  logic                  fill_hit;
  logic                  pass_hit;
  logic                  last_acc;
  logic                  drain_rd;

  assign fill_hit = bus.di_en && !in_cnt[FFT_LOGN-1];
  assign pass_hit = bus.di_en &&  in_cnt[FFT_LOGN-1];
  assign last_acc = bus.di_en && (in_cnt == FFT_LOGN'(FFT_N - 1));
  assign drain_rd = (state_q == ST_DRAIN);

  shift_ram #(.WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (fill_hit),
    .waddr ({wr_bank, in_cnt[FFT_LOGN-2:0]}),
    .wdata ({bus.di_re, bus.di_im}),
    .re    (drain_rd),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (rdata)
  );

  // Drain sequencer next state: start on bin 63, stop after the 32nd read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (last_acc) state_d = ST_DRAIN;
      ST_DRAIN: if (rd_cnt == (FFT_LOGN-1)'(FFT_HALF - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Frame counters, bank pointers and drain state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      in_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.di_en) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (last_acc) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
      end
      rd_cnt <= drain_rd ? rd_cnt + 1'b1 : '0;
    end
  end

  // Pass-through register for bins 32..63, zeroed when no pass sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_en  <= 1'b0;
      pass_re  <= '0;
      pass_im  <= '0;
      pass_k   <= '0;
      pass_sof <= 1'b0;
    end else begin
      pass_en  <= pass_hit;
      pass_re  <= pass_hit ? bus.di_re : '0;
      pass_im  <= pass_hit ? bus.di_im : '0;
      pass_k   <= pass_hit ? bin_to_k(in_cnt) : '0;
      pass_sof <= pass_hit && (in_cnt == FFT_LOGN'(FFT_HALF));
    end
  end

  // Drain side tags, aligned with the registered RAM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_k     <= '0;
    end else begin
      rd_valid <= drain_rd;
      rd_k     <= drain_rd ? bin_to_k({1'b0, rd_cnt}) : '0;
    end
  end

  // Output mux of two registered sources; they never overlap in time.
  assign bus.do_en     = pass_en | rd_valid;
  assign bus.do_re     = rd_valid ? rdata[2*WIDTH-1:WIDTH] : pass_re;
  assign bus.do_im     = rd_valid ? rdata[WIDTH-1:0]       : pass_im;
  assign bus.do_k      = rd_valid ? rd_k : pass_k;
  assign bus.do_sof    = pass_sof;
  assign bus.dbg_state = state_q;

endmodule
